// File: rtl/pong_engine_if.sv
// Bus between the VGA timing generator / player inputs and the pong game engine.
// The timing side (master) drives beam counters, frame tick and buttons; the
// engine (slave) returns the pixel word, scores and game-over flag.
interface pong_engine_if;
  logic [11:0] hcount;
  logic [10:0] vcount;
  logic        frame_tick;
  logic [1:0]  btn_up;
  logic [1:0]  btn_dn;
  logic [7:0]  data;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic        game_over;

  modport master (
    output hcount, vcount, frame_tick, btn_up, btn_dn,
    input  data, score_l, score_r, game_over
  );

  modport slave (
    input  hcount, vcount, frame_tick, btn_up, btn_dn,
    output data, score_l, score_r, game_over
  );
endinterface

// File: rtl/pong_engine.sv
// Pong game-state and pixel-colour stage. Object state advances once per
// frame_tick; the pixel word is registered from the current beam position.
module pong_engine #(
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic          CLK25,
  input  logic          rst_n,
  pong_engine_if.slave  pif
);

  localparam int FIELD_W = 640;
  localparam int FIELD_H = 480;
  localparam int L_PAD_X0 = 16;
  localparam int L_PAD_X1 = 23;
  localparam int R_PAD_X0 = 616;
  localparam int R_PAD_X1 = 623;
  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0] BALL_X0 = 10'((FIELD_W - BALL_SIZE) / 2);
  localparam logic [9:0] BALL_Y0 = 10'((FIELD_H - BALL_SIZE) / 2);
  localparam logic [9:0] PAD_Y0  = 10'((FIELD_H - PADDLE_H) / 2);
  localparam logic [9:0] L_HIT_X = 10'(L_PAD_X1 + 1);
  localparam logic [9:0] R_HIT_X = 10'(R_PAD_X0 - BALL_SIZE);

  localparam logic signed [11:0] S_PSPD = 12'(PADDLE_SPEED);
  localparam logic signed [11:0] S_PMAX = 12'(FIELD_H - PADDLE_H);
  localparam logic signed [11:0] S_BSPD = 12'(BALL_SPEED);
  localparam logic signed [11:0] S_BSZ  = 12'(BALL_SIZE);
  localparam logic signed [11:0] S_YMAX = 12'(FIELD_H - BALL_SIZE);
  localparam logic signed [11:0] S_XMAX = 12'(FIELD_W - BALL_SIZE);
  localparam logic signed [11:0] S_LHIT = 12'(L_PAD_X1 + 1);
  localparam logic signed [11:0] S_LOUT = 12'(L_PAD_X0 - BALL_SIZE);
  localparam logic signed [11:0] S_RPAD = 12'(R_PAD_X0);
  localparam logic signed [11:0] S_RIN  = 12'(R_PAD_X1 + 1);

  localparam logic [11:0] U_BSZ = 12'(BALL_SIZE);
  localparam logic [11:0] U_PH  = 12'(PADDLE_H);
  localparam logic [3:0]  WIN   = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_SCORED, S_GAMEOVER} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       bx_q, bx_d, by_q, by_d;
  logic             vxn_q, vxn_d, vyn_q, vyn_d;
  logic [9:0]       ltop_q, ltop_d, rtop_q, rtop_d;
  logic [3:0]       sl_q, sl_d, sr_q, sr_d;
  logic             scorer_r_q, scorer_r_d;
  logic [7:0]       data_q, data_d;

  logic signed [11:0] nx, ny;
  logic               ov_l, ov_r;
  logic [11:0]        px, py;
  logic               active, on_ball, on_pad, on_net;

  // One frame of paddle motion: opposing buttons cancel, result clamped to the field.
  function automatic logic [9:0] paddle_step(input logic [9:0] top, input logic up,
                                             input logic dn);
    logic signed [11:0] t;
    t = $signed({2'b00, top});
    if (up && !dn) t = t - S_PSPD;
    if (dn && !up) t = t + S_PSPD;
    if (t < 0) t = '0;
    else if (t > S_PMAX) t = S_PMAX;
    return t[9:0];
  endfunction

  // Ball rows [by, by+BALL_SIZE) intersect paddle rows [top, top+PADDLE_H).
  function automatic logic overlap(input logic [9:0] by, input logic [9:0] top);
    return (({2'b00, by} + U_BSZ) > {2'b00, top}) && ({2'b00, by} < ({2'b00, top} + U_PH));
  endfunction

  // Per-frame game update: paddles, ball physics, scoring and state transitions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bx_d       = bx_q;
    by_d       = by_q;
    vxn_d      = vxn_q;
    vyn_d      = vyn_q;
    ltop_d     = ltop_q;
    rtop_d     = rtop_q;
    sl_d       = sl_q;
    sr_d       = sr_q;
    scorer_r_d = scorer_r_q;
    nx   = $signed({2'b00, bx_q}) + (vxn_q ? -S_BSPD : S_BSPD);
    ny   = $signed({2'b00, by_q}) + (vyn_q ? -S_BSPD : S_BSPD);
    ov_l = overlap(by_q, ltop_q);
    ov_r = overlap(by_q, rtop_q);
    if (pif.frame_tick) begin
      if (state_q != S_GAMEOVER) begin
        ltop_d = paddle_step(ltop_q, pif.btn_up[0], pif.btn_dn[0]);
        rtop_d = paddle_step(rtop_q, pif.btn_up[1], pif.btn_dn[1]);
      end
      case (state_q)
        S_SERVE: begin
          bx_d = BALL_X0;
          by_d = BALL_Y0;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_PLAY: begin
          if (ny <= 0) begin
            by_d  = '0;
            vyn_d = 1'b0;
          end else if (ny >= S_YMAX) begin
            by_d  = S_YMAX[9:0];
            vyn_d = 1'b1;
          end else begin
            by_d = ny[9:0];
          end
          if (vxn_q && nx <= S_LHIT && nx > S_LOUT && ov_l) begin
            bx_d  = L_HIT_X;
            vxn_d = 1'b0;
          end else if (!vxn_q && (nx + S_BSZ) >= S_RPAD && nx < S_RIN && ov_r) begin
            bx_d  = R_HIT_X;
            vxn_d = 1'b1;
          end else if (nx <= 0) begin
            scorer_r_d = 1'b1;
            state_d    = S_SCORED;
          end else if (nx >= S_XMAX) begin
            scorer_r_d = 1'b0;
            state_d    = S_SCORED;
          end else begin
            bx_d = nx[9:0];
          end
        end
        S_SCORED: begin
          // Next serve heads toward whoever conceded the point.
          if (scorer_r_q) begin
            sr_d  = sr_q + 1'b1;
            vxn_d = 1'b1;
          end else begin
            sl_d  = sl_q + 1'b1;
            vxn_d = 1'b0;
          end
          vyn_d   = 1'b0;
          bx_d    = BALL_X0;
          by_d    = BALL_Y0;
          cnt_d   = '0;
          state_d = (sl_d == WIN || sr_d == WIN) ? S_GAMEOVER : S_SERVE;
        end
        S_GAMEOVER: begin
          if (|{pif.btn_up, pif.btn_dn}) begin
            sl_d    = '0;
            sr_d    = '0;
            bx_d    = BALL_X0;
            by_d    = BALL_Y0;
            ltop_d  = PAD_Y0;
            rtop_d  = PAD_Y0;
            vxn_d   = 1'b0;
            vyn_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_SERVE;
          end
        end
        default: state_d = S_SERVE;
      endcase
    end
  end

  // Game state registers.
  always_ff @(posedge CLK25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_SERVE;
      cnt_q      <= '0;
      bx_q       <= BALL_X0;
      by_q       <= BALL_Y0;
      vxn_q      <= 1'b0;
      vyn_q      <= 1'b0;
      ltop_q     <= PAD_Y0;
      rtop_q     <= PAD_Y0;
      sl_q       <= '0;
      sr_q       <= '0;
      scorer_r_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      vxn_q      <= vxn_d;
      vyn_q      <= vyn_d;
      ltop_q     <= ltop_d;
      rtop_q     <= rtop_d;
      sl_q       <= sl_d;
      sr_q       <= sr_d;
      scorer_r_q <= scorer_r_d;
    end
  end

  // Pixel colour for the current beam position, by object priority.
  always_comb begin
    px      = pif.hcount - 12'd144;
    py      = {1'b0, pif.vcount} - 12'd35;
    active  = (pif.hcount >= 12'd144) && (pif.hcount <= 12'd783) &&
              (pif.vcount >= 11'd35) && (pif.vcount <= 11'd512);
    on_ball = (px >= {2'b00, bx_q}) && (px < ({2'b00, bx_q} + U_BSZ)) &&
              (py >= {2'b00, by_q}) && (py < ({2'b00, by_q} + U_BSZ));
    on_pad  = ((px >= 12'(L_PAD_X0)) && (px <= 12'(L_PAD_X1)) &&
               (py >= {2'b00, ltop_q}) && (py < ({2'b00, ltop_q} + U_PH))) ||
              ((px >= 12'(R_PAD_X0)) && (px <= 12'(R_PAD_X1)) &&
               (py >= {2'b00, rtop_q}) && (py < ({2'b00, rtop_q} + U_PH)));
    on_net  = (px >= 12'd318) && (px <= 12'd321) && !py[4];
    data_d  = 8'h00;
    if (active) begin
      if (on_ball)                      data_d = 8'hFF;
      else if (on_pad)                  data_d = 8'h38;
      else if (on_net)                  data_d = 8'h92;
      else if (state_q == S_GAMEOVER)   data_d = 8'h04;
    end
  end

  // Registered pixel output, one cycle behind the beam counters.
  always_ff @(posedge CLK25 or negedge rst_n) begin
    if (!rst_n) data_q <= 8'h00;
    else        data_q <= data_d;
  end

  assign pif.data      = data_q;
  assign pif.score_l   = sl_q;
  assign pif.score_r   = sr_q;
  assign pif.game_over = (state_q == S_GAMEOVER);

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: a scripted game with hand-computed ball,
// paddle and score positions observed through the pixel output.
module tb_pong_engine;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pong_engine_if pif();

  pong_engine dut (.CLK25(clk), .rst_n(rst_n), .pif(pif));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raw beam position -> registered pixel one cycle later.
  task automatic pix_raw(input string tag, input int h, input int v, input logic [7:0] exp);
    pif.hcount = 12'(h);
    pif.vcount = 11'(v);
    @(posedge clk); #1;
    chk(tag, pif.data, exp);
  endtask

  // Field coordinate probe.
  task automatic pix(input string tag, input int x, input int y, input logic [7:0] exp);
    pix_raw(tag, 144 + x, 35 + y, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      pif.frame_tick = 1'b1;
      @(posedge clk); #1;
      pif.frame_tick = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pif.hcount = '0;
    pif.vcount = '0;
    pif.frame_tick = 1'b0;
    pif.btn_up = 2'b00;
    pif.btn_dn = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", pif.data, 8'h00);
    chk("rst_sl", {4'h0, pif.score_l}, 8'h00);
    chk("rst_sr", {4'h0, pif.score_r}, 8'h00);
    chk("rst_go", {7'h0, pif.game_over}, 8'h00);
    rst_n = 1'b1;

    // Initial picture
    pix_raw("ball_ctr", 460, 271, 8'hFF);
    pix_raw("blank_h", 100, 271, 8'h00);
    pix("lpad_init", 16, 208, 8'h38);
    pix("net_top", 318, 0, 8'h92);
    pix("net_gap", 318, 16, 8'h00);
    pix("bg", 100, 100, 8'h00);

    // Serve with left up, right both held
    pif.btn_up = 2'b11;
    pif.btn_dn = 2'b10;
    tick(59);
    pix("serve59", 316, 236, 8'hFF);
    tick(1);
    pix("serve60", 316, 236, 8'hFF);
    pif.btn_up = 2'b00;
    pif.btn_dn = 2'b00;
    pix("lpad_top0", 16, 0, 8'h38);
    pix("lpad_bot63", 16, 63, 8'h38);
    pix("lpad_below", 16, 64, 8'h00);
    pix("rpad_hold_top", 616, 208, 8'h38);
    pix("rpad_hold_above", 616, 207, 8'h00);
    pix("rpad_hold_bot", 616, 271, 8'h38);
    pix("rpad_hold_below", 616, 272, 8'h00);

    // First play frame
    tick(1);
    pix("k1_ball", 319, 239, 8'hFF);
    pix("k1_ball_br", 326, 246, 8'hFF);
    pix("k1_right", 327, 239, 8'h00);
    pix("k1_old", 316, 236, 8'h00);

    // Both paddles down 52 frames: right 416, left 208
    pif.btn_dn = 2'b11;
    tick(52);
    pix("rpad_416", 616, 416, 8'h38);
    pix("rpad_415", 616, 415, 8'h00);
    pix("lpad_208", 16, 208, 8'h38);
    pif.btn_dn = 2'b01;
    tick(25);
    pix("k78_ball", 550, 470, 8'hFF);
    pix("k78_above", 550, 469, 8'h00);
    tick(1);
    pix("k79_floor", 553, 472, 8'hFF);
    pix("k79_above", 553, 471, 8'h00);
    tick(1);
    pix("k80_up", 556, 469, 8'hFF);
    pix("k80_below", 556, 477, 8'h00);
    tick(18);
    pix("rhit_x608", 608, 415, 8'hFF);
    pix("rhit_left", 607, 415, 8'h00);
    tick(1);
    pix("k99_ball", 605, 412, 8'hFF);
    pix("k99_left", 604, 412, 8'h00);
    tick(6);
    pif.btn_dn = 2'b00;
    pix("lpad_416", 16, 416, 8'h38);
    pix("lpad_415", 16, 415, 8'h00);

    // Leftward: top bounce then left miss
    tick(132);
    pix("top_y0", 191, 0, 8'hFF);
    tick(1);
    pix("top_y3", 188, 3, 8'hFF);
    pix("top_y2", 188, 2, 8'h00);
    tick(63);
    chk("sr_before", {4'h0, pif.score_r}, 8'h00);
    tick(1);
    chk("sr_after", {4'h0, pif.score_r}, 8'h01);
    chk("sl_still0", {4'h0, pif.score_l}, 8'h00);

    // Serve toward left, left paddle hit
    tick(59);
    pix("serve2_ctr", 316, 236, 8'hFF);
    tick(2);
    pix("m1_ball", 313, 239, 8'hFF);
    pix("m1_net", 321, 239, 8'h92);
    pix("m1_left", 312, 239, 8'h00);
    tick(97);
    pix("lhit_x24", 24, 415, 8'hFF);
    pix("lhit_pad", 23, 416, 8'h38);
    chk("lhit_sr", {4'h0, pif.score_r}, 8'h01);
    chk("lhit_sl", {4'h0, pif.score_l}, 8'h00);
    tick(1);
    pix("m99_ball", 27, 412, 8'hFF);
    pix("m99_left", 26, 412, 8'h00);

    // Rightward: right miss scores for left
    tick(202);
    chk("sl_before", {4'h0, pif.score_l}, 8'h00);
    tick(1);
    chk("sl_1", {4'h0, pif.score_l}, 8'h01);

    // Right paddle back to 208, then repeated right misses
    pif.btn_up = 2'b10;
    tick(52);
    pif.btn_up = 2'b00;
    tick(115);
    chk("sl_2", {4'h0, pif.score_l}, 8'h02);
    pix("rpad_back", 616, 208, 8'h38);
    for (int p = 3; p <= 9; p++) begin
      chk("go_low", {7'h0, pif.game_over}, 8'h00);
      tick(167);
      chk("sl_n", {4'h0, pif.score_l}, 8'(p));
    end
    chk("go_high", {7'h0, pif.game_over}, 8'h01);
    chk("go_sr", {4'h0, pif.score_r}, 8'h01);
    pix("go_bg", 100, 100, 8'h04);
    pix_raw("go_blank", 100, 135, 8'h00);
    pix("go_net", 318, 0, 8'h92);
    tick(3);
    chk("go_hold", {7'h0, pif.game_over}, 8'h01);

    // Restart
    pif.btn_dn = 2'b10;
    tick(1);
    pif.btn_dn = 2'b00;
    chk("rs_sl", {4'h0, pif.score_l}, 8'h00);
    chk("rs_sr", {4'h0, pif.score_r}, 8'h00);
    chk("rs_go", {7'h0, pif.game_over}, 8'h00);
    pix("rs_lpad", 16, 208, 8'h38);
    pix("rs_lpad_old", 16, 416, 8'h00);
    pix("rs_ball", 316, 236, 8'hFF);

    // Point for left, then reset mid-play
    tick(167);
    chk("rs_sl1", {4'h0, pif.score_l}, 8'h01);
    tick(65);
    pix("k5_ball", 331, 251, 8'hFF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_data", pif.data, 8'h00);
    chk("arst_sl", {4'h0, pif.score_l}, 8'h00);
    chk("arst_go", {7'h0, pif.game_over}, 8'h00);
    pif.frame_tick = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pif.frame_tick = 1'b0;
    rst_n = 1'b1;
    tick(60);
    pix("arst_ctr", 316, 236, 8'hFF);
    tick(1);
    pix("arst_k1", 319, 239, 8'hFF);
    pix("arst_k1_old", 316, 236, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
